spread: RTL and testbench
=========================

# spread

Direct-sequence spreader. Each accepted input bit is expanded into SPREAD output chips, one per clock: chip k = data bit XOR code bit k. It sits between the bit source (framer/scrambler) and the chip-rate modulator. A ready/valid handshake on the input side stalls the source while a bit is being spread.

## Interface
- SPREAD, 24: chips per input bit; legal range is 2 or more.
- CODE, 24'hF9A42B: spreading code of SPREAD bits, sent MSB first (CODE[SPREAD-1] is chip 0).
- i_clk  in  1  clock; all logic is rising-edge.
- i_reset  in  1  synchronous, active-high reset; clock i_clk.
- o_ready  out  1  block can accept a bit this cycle (registered).
- i_data  in  1  input bit.
- i_valid  in  1  i_data is valid; a transfer occurs on a rising edge where i_valid and o_ready are both 1.
- o_data  out  1  current chip (registered).
- o_valid  out  1  o_data holds a valid chip (registered).

## Operation
- Two states: IDLE and SEND. A chip counter cnt is $clog2(SPREAD) bits wide, and a 1-bit register holds the latched bit.
- IDLE: o_ready=1, o_valid=0. On a transfer, latch i_data, set cnt=0, and go to SEND.
- SEND: o_data = bit ^ CODE[SPREAD-1-cnt] and o_valid=1. cnt increments by 1 every cycle.
- o_ready is 0 in SEND, except while cnt==SPREAD-1 (last chip), when it is 1.
- Transfer during the last chip: latch the new bit, cnt wraps to 0, stay in SEND. Chips continue with no gap.
- No transfer at the last chip: go to IDLE. o_valid=0, o_data=0.
- i_valid while o_ready=0 is ignored and i_data is not sampled. The source must hold i_valid and i_data until o_ready is seen.
- No internal buffering beyond the one latched bit.

## Timing
- Reset values: o_ready=0, o_valid=0, o_data=0, state=IDLE, cnt=0.
- First rising edge with i_reset=0 sets o_ready=1.
- Latency: transfer at edge E puts chip 0 on o_data after E. Chip k appears after edge E+k. o_valid stays 1 for exactly SPREAD consecutive cycles per bit.
- Single isolated bit: o_ready drops after E and rises again after edge E+SPREAD-1, together with the last chip.
- Sustained input: one bit per SPREAD cycles, continuous chips, o_valid never drops.
- i_reset asserted mid-burst aborts it. On the next edge all outputs take their reset values, and the partial bit is discarded.
- i_reset has priority over a simultaneous transfer.

## Structure
- spread_pkg holds the default code constant (SPREAD_CODE_24 = 24'hF9A42B) and the state enum type (IDLE, SEND).
- Optional sub-module spread_chip_gen: a combinational mux that takes (cnt, bit) and returns the chip. The top level holds the FSM and handshake.
- Elaboration check: SPREAD>=2 and $bits(CODE)==SPREAD.

## Test plan
- Reset, then release: o_ready=0, o_valid=0, o_data=0 during reset. o_ready=1 one edge after release.
- Send data=0: 24 chips equal to 1111 1001 1010 0100 0010 1011 (MSB first), o_valid high for 24 cycles.
- Send data=1: chips are 0000 0110 0101 1011 1101 0100, i.e. the inverted code.
- Drive i_valid registered from o_ready (one-cycle lag), bits 1,0,1: o_ready pulses three times, each bit produces a correct 24-chip burst, and there is no transfer while o_ready=0.
- Hold i_valid=1 continuously, alternating data: 72 contiguous chips, o_valid never drops, o_ready=1 only on chips 23, 47 and 71.
- Assert i_reset at chip 10: outputs are 0 after the next edge, and the next accepted bit restarts at chip 0.

Source files
------------

// File: rtl/spread_pkg.sv
// Shared types and constants for the direct-sequence spreader.
package spread_pkg;

   localparam int SPREAD_DEFAULT = 24;
   localparam logic [23:0] SPREAD_CODE_24 = 24'hF9A42B;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

endpackage

// File: rtl/spread_chip_gen.sv
// Combinational chip selector: returns data bit XOR code bit for chip index cnt.
// Chip 0 uses the code MSB.
module spread_chip_gen
   import spread_pkg::*;
#(
   parameter int SPREAD = SPREAD_DEFAULT,
   parameter logic [SPREAD-1:0] CODE = SPREAD_CODE_24
) (
   input  logic [$clog2(SPREAD)-1:0] cnt,
   input  logic                      data_bit,
   output logic                      chip
);

   localparam int CW = $clog2(SPREAD);
   localparam logic [CW-1:0] LAST = CW'(SPREAD - 1);

   assign chip = data_bit ^ CODE[LAST - cnt];

endmodule

// File: rtl/spread.sv
// Direct-sequence spreader: one accepted bit becomes SPREAD chips, one per clock.
// All outputs are registered; o_ready reopens on the last chip so bursts can run back to back.
module spread
   import spread_pkg::*;
#(
   parameter int SPREAD = SPREAD_DEFAULT,
   parameter logic [SPREAD-1:0] CODE = SPREAD_CODE_24
) (
   input  logic i_clk,
   input  logic i_reset,
   output logic o_ready,
   input  logic i_data,
   input  logic i_valid,
   output logic o_data,
   output logic o_valid
);

   localparam int CW = $clog2(SPREAD);
   localparam logic [CW-1:0] LAST = CW'(SPREAD - 1);

   generate
      if (SPREAD < 2 || $bits(CODE) != SPREAD) begin : g_bad_params
         $error("spread: SPREAD must be >= 2 and CODE must be SPREAD bits wide");
      end
   endgenerate

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            bit_q, bit_nxt;
   logic            chip_nxt;
   logic            xfer;

   assign xfer = i_valid && o_ready;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_q;
      case (state)
         IDLE: begin
            if (xfer) begin
               state_nxt = SEND;
               cnt_nxt   = '0;
               bit_nxt   = i_data;
            end
         end
         SEND: begin
            if (cnt == LAST) begin
               cnt_nxt = '0;
               if (xfer) begin
                  bit_nxt = i_data;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are computed from next-state values so they stay registered yet align with cnt.
   spread_chip_gen #(
      .SPREAD (SPREAD),
      .CODE   (CODE)
   ) u_chip_gen (
      .cnt      (cnt_nxt),
      .data_bit (bit_nxt),
      .chip     (chip_nxt)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_q   <= 1'b0;
         o_ready <= 1'b0;
         o_valid <= 1'b0;
         o_data  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_q   <= bit_nxt;
         o_ready <= (state_nxt == IDLE) || (cnt_nxt == LAST);
         o_valid <= (state_nxt == SEND);
         o_data  <= (state_nxt == SEND) && chip_nxt;
      end
   end

endmodule

// File: tb/tb_spread.sv
// Bench for spread: directed scenarios plus random traffic, checked every cycle
// against a chip-queue model of the spreader.
module tb_spread;

   localparam int SPREAD = 24;
   localparam logic [23:0] CODE = 24'hF9A42B;

   logic i_clk = 1'b0;
   logic i_reset = 1'b1;
   logic i_data = 1'b0;
   logic i_valid = 1'b0;
   logic o_ready, o_data, o_valid;

   int n_assert = 0;
   int n_fail = 0;

   spread #(.SPREAD(SPREAD), .CODE(CODE)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .o_ready (o_ready),
      .i_data  (i_data),
      .i_valid (i_valid),
      .o_data  (o_data),
      .o_valid (o_valid)
   );

   always #5 i_clk = ~i_clk;

   // Model: a transfer queues the bit's whole chip sequence; each clock shows the next chip.
   logic code_v [SPREAD];
   logic chipq [$];
   logic exp_ready = 1'b0, exp_valid = 1'b0, exp_data = 1'b0;
   logic last_xfer = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input string tag);
      logic xfer;
      xfer = !i_reset && i_valid && exp_ready;
      if (i_reset) begin
         chipq.delete();
         exp_ready = 1'b0;
         exp_valid = 1'b0;
         exp_data  = 1'b0;
      end else begin
         if (xfer)
            for (int k = 0; k < SPREAD; k++) chipq.push_back(i_data ^ code_v[k]);
         if (chipq.size() > 0) begin
            exp_data  = chipq.pop_front();
            exp_valid = 1'b1;
         end else begin
            exp_data  = 1'b0;
            exp_valid = 1'b0;
         end
         exp_ready = (chipq.size() == 0);
      end
      last_xfer = xfer;
      @(posedge i_clk);
      #1;
      chk({tag, ".ready"}, 32'(o_ready), 32'(exp_ready));
      chk({tag, ".valid"}, 32'(o_valid), 32'(exp_valid));
      chk({tag, ".data"},  32'(o_data),  32'(exp_data));
   endtask

   // Sends one bit from idle and collects its chips MSB-first.
   task automatic send_one(input logic b, output logic [23:0] chips, output int vcnt);
      chips = '0;
      vcnt  = 0;
      i_valid = 1'b1;
      i_data  = b;
      step("xfer");
      i_valid = 1'b0;
      for (int c = 0; c < SPREAD + 3; c++) begin
         if (o_valid) begin
            chips = {chips[22:0], o_data};
            vcnt++;
         end
         step("burst");
      end
   endtask

   initial begin
      logic [23:0] chips;
      logic [23:0] inv_code;
      logic        bits3 [3];
      logic        prev_ready;
      int          vcnt, rcnt, idx, sent;

      for (int k = 0; k < SPREAD; k++) code_v[k] = CODE[SPREAD-1-k];
      inv_code = ~CODE;

      // Reset and release
      i_reset = 1'b1;
      step("rst");
      step("rst");
      i_reset = 1'b0;
      step("release");
      step("idle");

      // Single bits
      send_one(1'b0, chips, vcnt);
      chk("code_d0", 32'(chips), 32'(CODE));
      chk("vcnt_d0", 32'(vcnt), 32'(SPREAD));
      send_one(1'b1, chips, vcnt);
      chk("code_d1", 32'(chips), 32'(inv_code));
      chk("vcnt_d1", 32'(vcnt), 32'(SPREAD));

      // i_valid registered from o_ready, bits 1,0,1
      bits3[0] = 1'b1; bits3[1] = 1'b0; bits3[2] = 1'b1;
      idx = 0;
      prev_ready = o_ready;
      i_valid = 1'b0;
      for (int c = 0; c < 120 && !(idx == 3 && !o_valid); c++) begin
         i_valid = (idx < 3) ? prev_ready : 1'b0;
         i_data  = bits3[(idx < 3) ? idx : 2];
         prev_ready = o_ready;
         step("lag");
         if (last_xfer) idx++;
      end
      i_valid = 1'b0;
      chk("lag_xfers", 32'(idx), 32'd3);
      step("lag_tail");

      // Continuous valid, alternating data: 72 gapless chips
      sent = 0; vcnt = 0; rcnt = 0;
      i_valid = 1'b1;
      i_data  = 1'b1;
      for (int c = 0; c < 90; c++) begin
         step("cont");
         if (last_xfer) begin
            sent++;
            i_data = ~i_data;
            if (sent == 3) i_valid = 1'b0;
         end
         if (o_valid) begin
            vcnt++;
            if (o_ready) rcnt++;
         end
         if (sent == 3 && !o_valid) break;
      end
      chk("cont_chips", 32'(vcnt), 32'd72);
      chk("cont_ready", 32'(rcnt), 32'd3);

      // Reset during chip 10
      i_valid = 1'b1;
      i_data  = 1'b0;
      step("pre_abort");
      i_valid = 1'b0;
      for (int c = 0; c < 10; c++) step("abort_run");
      i_reset = 1'b1;
      step("abort");
      i_reset = 1'b0;
      step("abort_rel");
      send_one(1'b1, chips, vcnt);
      chk("restart_code", 32'(chips), 32'(inv_code));

      // Random traffic; source holds i_valid/i_data until accepted
      i_valid = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         if (!i_valid || last_xfer) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_data  = 1'($urandom);
         end
         i_reset = ($urandom_range(0, 299) == 0);
         if (i_reset) i_valid = 1'b0;
         step("rand");
      end
      i_reset = 1'b0;
      i_valid = 1'b0;
      for (int c = 0; c < SPREAD + 2; c++) step("drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
